// File: rtl/fwd_hazard_ctrl_pkg.sv
// rtl/fwd_hazard_ctrl_pkg.sv - shared constants and types for the EX-stage forwarding/hazard controller
// Contents:
//   FWD_NONE / STG_*     : "no winning stage" marker and downstream stage indices (0 = youngest)
//   REG_W_DEF/WORD_W_DEF : default register-index and datapath widths
//   stall_cause_e        : stall cause encodings for debug visibility
//   mdu_state_e          : MDU scoreboard FSM states
package fwd_hazard_ctrl_pkg;

    localparam int FWD_NONE   = -1;
    localparam int STG_MEM    = 0;
    localparam int STG_WB     = 1;
    localparam int STG_WB2    = 2;

    localparam int REG_W_DEF  = 5;
    localparam int WORD_W_DEF = 32;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_LOADUSE = 2'd1,
        CAUSE_MDU     = 2'd2
    } stall_cause_e;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/fwd_src_select.sv
// rtl/fwd_src_select.sv - one EX operand against all downstream write stages
// Ports:
//   i_idx       : operand register index
//   i_use       : operand is actually read
//   i_wreg      : destination register per stage, stage j at [j*REG_W +: REG_W]
//   i_wdata     : write value per stage, stage j at [j*DATA_W +: DATA_W]
//   i_data_ok   : per-stage "value is final" flag
//   o_fwd       : operand takes o_data
//   o_data      : bypass value, 0 when not forwarding
//   o_not_ready : youngest match is not ready and the operand is read (load-use)
module fwd_src_select
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int NUM_FWD = 3,
    parameter int DATA_W  = WORD_W_DEF,
    parameter int REG_W   = REG_W_DEF
) (
    input  logic [REG_W-1:0]          i_idx,
    input  logic                      i_use,
    input  logic [NUM_FWD*REG_W-1:0]  i_wreg,
    input  logic [NUM_FWD*DATA_W-1:0] i_wdata,
    input  logic [NUM_FWD-1:0]        i_data_ok,
    output logic                      o_fwd,
    output logic [DATA_W-1:0]         o_data,
    output logic                      o_not_ready
);

    logic              w_hit;
    logic              w_ok;
    logic [DATA_W-1:0] w_data;

    // Scan oldest to youngest so the youngest match overwrites; a stage that
    // does not write (wreg 0) can never match, which also keeps r0 unforwarded.
    always_comb begin
        w_hit  = 1'b0;
        w_ok   = 1'b0;
        w_data = '0;
        for (int j = NUM_FWD - 1; j >= 0; j--) begin
            if ((i_wreg[j*REG_W +: REG_W] != '0) && (i_wreg[j*REG_W +: REG_W] == i_idx)) begin
                w_hit  = 1'b1;
                w_ok   = i_data_ok[j];
                w_data = i_wdata[j*DATA_W +: DATA_W];
            end
        end
    end

    assign o_fwd       = w_hit & w_ok;
    assign o_data      = (w_hit & w_ok) ? w_data : '0;
    assign o_not_ready = w_hit & ~w_ok & i_use;

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// rtl/fwd_hazard_ctrl.sv - EX-stage forwarding, load-use/MDU stall and stall monitoring
// Ports:
//   i_clk, i_reset                 : clock, synchronous active-high reset
//   i_ex_valid, i_ex_src_idx/_use  : EX instruction and its source operands
//   i_stg_wreg/_wdata/_data_ok     : downstream stage writes (index 0 = MEM, youngest)
//   i_mdu_start, i_mdu_wreg        : multi-cycle MDU issue and its destination
//   i_flush                        : cancels the pending MDU entry
//   o_src_fwd, o_src_fwd_data      : per-operand bypass select and value
//   o_stall                        : hold IF/ID/EX, bubble into MEM
//   o_mdu_busy, o_mdu_done         : scoreboard pending / last-cycle pulse
//   o_stall_cnt, o_hang, o_mdu_err : saturating stall count, sticky hang, sticky MDU overlap
module fwd_hazard_ctrl
    import fwd_hazard_ctrl_pkg::*;
#(
    parameter int NUM_SRC   = 2,
    parameter int NUM_FWD   = 3,
    parameter int DATA_W    = 32,
    parameter int REG_W     = 5,
    parameter int MDU_LAT   = 4,
    parameter int MAX_STALL = 64
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_ex_valid,
    input  logic [NUM_SRC*REG_W-1:0]  i_ex_src_idx,
    input  logic [NUM_SRC-1:0]        i_ex_src_use,
    input  logic [NUM_FWD*REG_W-1:0]  i_stg_wreg,
    input  logic [NUM_FWD*DATA_W-1:0] i_stg_wdata,
    input  logic [NUM_FWD-1:0]        i_stg_data_ok,
    input  logic                      i_mdu_start,
    input  logic [REG_W-1:0]          i_mdu_wreg,
    input  logic                      i_flush,
    output logic [NUM_SRC-1:0]        o_src_fwd,
    output logic [NUM_SRC*DATA_W-1:0] o_src_fwd_data,
    output logic                      o_stall,
    output logic                      o_mdu_busy,
    output logic                      o_mdu_done,
    output logic [31:0]               o_stall_cnt,
    output logic                      o_hang,
    output logic                      o_mdu_err
);

    localparam int CNT_W = $clog2(MDU_LAT + 1);
    localparam int RUN_W = $clog2(MAX_STALL + 1);

    mdu_state_e       r_state;
    mdu_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [REG_W-1:0] r_pend;
    logic [REG_W-1:0] w_pend_nxt;
    logic             r_err;
    logic             w_err_nxt;
    logic [31:0]      r_stall_cnt;
    logic [RUN_W-1:0] r_run;
    logic             r_hang;

    logic [NUM_SRC-1:0] w_loaduse;
    logic               w_mdu_hz;
    logic               w_stall;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            fwd_src_select #(
                .NUM_FWD (NUM_FWD),
                .DATA_W  (DATA_W),
                .REG_W   (REG_W)
            ) u_sel (
                .i_idx       (i_ex_src_idx[gi*REG_W +: REG_W]),
                .i_use       (i_ex_src_use[gi]),
                .i_wreg      (i_stg_wreg),
                .i_wdata     (i_stg_wdata),
                .i_data_ok   (i_stg_data_ok),
                .o_fwd       (o_src_fwd[gi]),
                .o_data      (o_src_fwd_data[gi*DATA_W +: DATA_W]),
                .o_not_ready (w_loaduse[gi])
            );
        end
    endgenerate

    // A pending MDU write to r0 occupies the unit but has nothing to protect.
    always_comb begin
        w_mdu_hz = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if ((r_state == MDU_BUSY) && i_ex_src_use[i] && (r_pend != '0) &&
                (i_ex_src_idx[i*REG_W +: REG_W] == r_pend)) begin
                w_mdu_hz = 1'b1;
            end
        end
    end

    assign w_stall = i_ex_valid & ~i_reset & ((|w_loaduse) | w_mdu_hz);

    // Scoreboard next state. Flush dominates everything, including a start in
    // the same cycle. While busy the countdown keeps running even if a new
    // start is (illegally) presented; the overlap is only recorded.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pend_nxt  = r_pend;
        w_err_nxt   = r_err;
        if (i_flush) begin
            w_state_nxt = MDU_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                MDU_IDLE: begin
                    if (i_mdu_start) begin
                        w_state_nxt = MDU_BUSY;
                        w_cnt_nxt   = CNT_W'(MDU_LAT);
                        w_pend_nxt  = i_mdu_wreg;
                    end
                end
                MDU_BUSY: begin
                    if (i_mdu_start) begin
                        w_err_nxt = 1'b1;
                    end
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_nxt = MDU_IDLE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = MDU_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= MDU_IDLE;
            r_cnt   <= '0;
            r_pend  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pend  <= w_pend_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // The run counter saturates at MAX_STALL; hang is latched on the stall
    // cycle that brings the run to MAX_STALL.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stall_cnt <= '0;
            r_run       <= '0;
            r_hang      <= 1'b0;
        end else begin
            if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_stall) begin
                if (r_run != RUN_W'(MAX_STALL)) begin
                    r_run <= r_run + RUN_W'(1);
                end
                if (r_run == RUN_W'(MAX_STALL - 1)) begin
                    r_hang <= 1'b1;
                end
            end else begin
                r_run <= '0;
            end
        end
    end

    assign o_stall     = w_stall;
    assign o_mdu_busy  = (r_state == MDU_BUSY);
    assign o_mdu_done  = (r_state == MDU_BUSY) && (r_cnt == CNT_W'(1));
    assign o_stall_cnt = r_stall_cnt;
    assign o_hang      = r_hang;
    assign o_mdu_err   = r_err;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb/tb_fwd_hazard_ctrl.sv - self-checking bench for fwd_hazard_ctrl
module tb_fwd_hazard_ctrl;

    localparam int NS   = 2;
    localparam int NF   = 3;
    localparam int DW   = 32;
    localparam int RW   = 5;
    localparam int LAT  = 4;
    localparam int MAXS = 64;

    logic             clk = 1'b0;
    logic             reset;
    logic             ex_valid;
    logic [NS*RW-1:0] ex_src_idx;
    logic [NS-1:0]    ex_src_use;
    logic [NF*RW-1:0] stg_wreg;
    logic [NF*DW-1:0] stg_wdata;
    logic [NF-1:0]    stg_data_ok;
    logic             mdu_start;
    logic [RW-1:0]    mdu_wreg;
    logic             flush;
    logic [NS-1:0]    src_fwd;
    logic [NS*DW-1:0] src_fwd_data;
    logic             stall;
    logic             mdu_busy;
    logic             mdu_done;
    logic [31:0]      stall_cnt;
    logic             hang;
    logic             mdu_err;

    int errors = 0;
    int checks = 0;

    // reference model state
    logic [31:0] m_stall_cnt;
    int          m_run;
    logic        m_hang;
    int          m_rem;
    logic [RW-1:0] m_reg;
    logic        m_err;

    fwd_hazard_ctrl #(
        .NUM_SRC(NS), .NUM_FWD(NF), .DATA_W(DW), .REG_W(RW), .MDU_LAT(LAT), .MAX_STALL(MAXS)
    ) dut (
        .i_clk(clk), .i_reset(reset), .i_ex_valid(ex_valid), .i_ex_src_idx(ex_src_idx),
        .i_ex_src_use(ex_src_use), .i_stg_wreg(stg_wreg), .i_stg_wdata(stg_wdata),
        .i_stg_data_ok(stg_data_ok), .i_mdu_start(mdu_start), .i_mdu_wreg(mdu_wreg),
        .i_flush(flush), .o_src_fwd(src_fwd), .o_src_fwd_data(src_fwd_data), .o_stall(stall),
        .o_mdu_busy(mdu_busy), .o_mdu_done(mdu_done), .o_stall_cnt(stall_cnt),
        .o_hang(hang), .o_mdu_err(mdu_err)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        ex_valid    = 1'b0;
        ex_src_idx  = '0;
        ex_src_use  = '0;
        stg_wreg    = '0;
        stg_wdata   = '0;
        stg_data_ok = '0;
        mdu_start   = 1'b0;
        mdu_wreg    = '0;
        flush       = 1'b0;
    endtask

    // Youngest-writer-wins forwarding computed straight from the rules.
    task automatic model_fwd(output logic [NS-1:0] f, output logic [NS*DW-1:0] d,
                             output logic lu, output logic [NS-1:0] cand);
        f = '0; d = '0; lu = 1'b0; cand = '0;
        for (int i = 0; i < NS; i++) begin
            for (int j = 0; j < NF; j++) begin
                if (!cand[i] && stg_wreg[j*RW +: RW] != 0 &&
                    stg_wreg[j*RW +: RW] == ex_src_idx[i*RW +: RW]) begin
                    cand[i] = 1'b1;
                    if (stg_data_ok[j]) begin
                        f[i] = 1'b1;
                        d[i*DW +: DW] = stg_wdata[j*DW +: DW];
                    end else if (ex_src_use[i]) begin
                        lu = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic model_stall(output logic s);
        logic [NS-1:0]    f;
        logic [NS*DW-1:0] d;
        logic             lu;
        logic [NS-1:0]    c;
        logic             mh;
        model_fwd(f, d, lu, c);
        mh = 1'b0;
        for (int i = 0; i < NS; i++)
            if (m_rem > 0 && ex_src_use[i] && m_reg != 0 && ex_src_idx[i*RW +: RW] == m_reg)
                mh = 1'b1;
        s = ex_valid && !reset && (lu || mh);
    endtask

    // Advance one clock, updating the model with the inputs present before the edge.
    task automatic step();
        logic s;
        model_stall(s);
        if (reset) begin
            m_stall_cnt = 0; m_run = 0; m_hang = 0; m_rem = 0; m_err = 0; m_reg = 0;
        end else begin
            if (s) begin
                if (m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
                m_run++;
                if (m_run == MAXS) m_hang = 1'b1;
            end else begin
                m_run = 0;
            end
            if (flush) m_rem = 0;
            else if (m_rem > 0) begin
                if (mdu_start) m_err = 1'b1;
                m_rem--;
            end else if (mdu_start) begin
                m_rem = LAT;
                m_reg = mdu_wreg;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        ex_valid = 1'b1; ex_src_idx[0 +: RW] = 5; ex_src_use = 2'b01;
        stg_wreg[0 +: RW] = 5; stg_data_ok = 3'b000;
        step(); step();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
        checks++; if (mdu_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", mdu_busy); end
        checks++; if (mdu_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", mdu_done); end
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); end
        checks++; if (hang !== 1'b0) begin errors++; $display("FAIL reset_hang got=%b exp=0", hang); end
        checks++; if (mdu_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", mdu_err); end
        reset = 1'b0;
        clear_inputs();
        step();
    endtask

    task automatic test_priority();
        clear_inputs();
        ex_valid = 1'b1; ex_src_idx[0 +: RW] = 5; ex_src_use = 2'b11;
        stg_wreg[0 +: RW] = 5; stg_wreg[RW +: RW] = 5;
        stg_wdata[0 +: DW] = 32'h11; stg_wdata[DW +: DW] = 32'h22; stg_data_ok = 3'b111;
        #1;
        checks++; if (src_fwd[0] !== 1'b1) begin errors++; $display("FAIL prio_fwd got=%b exp=1", src_fwd[0]); end
        checks++; if (src_fwd_data[0 +: DW] !== 32'h11) begin errors++; $display("FAIL prio_data got=%h exp=11", src_fwd_data[0 +: DW]); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL prio_stall got=%b exp=0", stall); end
        stg_wreg[0 +: RW] = 0;
        #1;
        checks++; if (src_fwd_data[0 +: DW] !== 32'h22) begin errors++; $display("FAIL prio_wb_data got=%h exp=22", src_fwd_data[0 +: DW]); end
        step();
    endtask

    task automatic test_load_use();
        clear_inputs();
        ex_valid = 1'b1; ex_src_idx[0 +: RW] = 5; ex_src_use = 2'b01;
        stg_wreg[0 +: RW] = 5; stg_wreg[RW +: RW] = 5;
        stg_wdata[DW +: DW] = 32'h22; stg_data_ok = 3'b010;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall got=%b exp=1", stall); end
        checks++; if (src_fwd[0] !== 1'b0) begin errors++; $display("FAIL lu_fwd got=%b exp=0", src_fwd[0]); end
        step();
        ex_src_use = 2'b00;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_unused_stall got=%b exp=0", stall); end
        step();
    endtask

    task automatic test_reg_zero();
        clear_inputs();
        ex_valid = 1'b1; ex_src_use = 2'b11; stg_data_ok = 3'b111;
        for (int j = 0; j < NF; j++) stg_wdata[j*DW +: DW] = 32'hDEAD;
        #1;
        checks++; if (src_fwd !== 2'b00) begin errors++; $display("FAIL r0_fwd got=%b exp=00", src_fwd); end
        checks++; if (src_fwd_data !== '0) begin errors++; $display("FAIL r0_data got=%h exp=0", src_fwd_data); end
        stg_data_ok = 3'b000;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL r0_stall got=%b exp=0", stall); end
        step();
    endtask

    task automatic test_random_fwd();
        logic [NS-1:0]    ef;
        logic [NS*DW-1:0] ed;
        logic             elu;
        logic [NS-1:0]    ec;
        logic             es;
        clear_inputs();
        for (int it = 0; it < 300; it++) begin
            ex_valid = ($urandom_range(0, 7) != 0);
            for (int i = 0; i < NS; i++) ex_src_idx[i*RW +: RW] = RW'($urandom_range(0, 3));
            ex_src_use = NS'($urandom);
            for (int j = 0; j < NF; j++) begin
                stg_wreg[j*RW +: RW]  = RW'($urandom_range(0, 3));
                stg_wdata[j*DW +: DW] = $urandom;
            end
            stg_data_ok = NF'($urandom);
            #1;
            model_fwd(ef, ed, elu, ec);
            es = ex_valid && elu;
            checks++; if (src_fwd !== ef) begin errors++; $display("FAIL rnd_fwd it=%0d got=%b exp=%b", it, src_fwd, ef); end
            checks++; if (stall !== es) begin errors++; $display("FAIL rnd_stall it=%0d got=%b exp=%b", it, stall, es); end
            for (int i = 0; i < NS; i++) begin
                if (ef[i] || !ec[i]) begin
                    checks++;
                    if (src_fwd_data[i*DW +: DW] !== ed[i*DW +: DW]) begin
                        errors++;
                        $display("FAIL rnd_data it=%0d op=%0d got=%h exp=%h", it, i, src_fwd_data[i*DW +: DW], ed[i*DW +: DW]);
                    end
                end
            end
            step();
        end
        checks++; if (stall_cnt !== m_stall_cnt) begin errors++; $display("FAIL rnd_stall_cnt got=%0d exp=%0d", stall_cnt, m_stall_cnt); end
    endtask

    task automatic test_mdu();
        clear_inputs();
        ex_valid = 1'b1; ex_src_idx[0 +: RW] = 8; ex_src_use = 2'b01;
        mdu_start = 1'b1; mdu_wreg = 8;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mdu_t0_stall got=%b exp=0", stall); end
        checks++; if (mdu_busy !== 1'b0) begin errors++; $display("FAIL mdu_t0_busy got=%b exp=0", mdu_busy); end
        step();
        mdu_start = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            if (k == 2) begin mdu_start = 1'b1; mdu_wreg = 9; end
            #1;
            checks++; if (mdu_busy !== (k <= 4)) begin errors++; $display("FAIL mdu_busy t+%0d got=%b exp=%b", k, mdu_busy, k <= 4); end
            checks++; if (stall !== (k <= 4)) begin errors++; $display("FAIL mdu_stall t+%0d got=%b exp=%b", k, stall, k <= 4); end
            checks++; if (mdu_done !== (k == 4)) begin errors++; $display("FAIL mdu_done t+%0d got=%b exp=%b", k, mdu_done, k == 4); end
            checks++; if (mdu_err !== (k >= 3)) begin errors++; $display("FAIL mdu_err t+%0d got=%b exp=%b", k, mdu_err, k >= 3); end
            step();
            mdu_start = 1'b0;
        end
        // r0 destination occupies the unit but never stalls a reader of r0
        ex_src_idx = '0; ex_src_use = 2'b11; mdu_wreg = 0; mdu_start = 1'b1;
        step();
        mdu_start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            #1;
            checks++; if (mdu_busy !== 1'b1) begin errors++; $display("FAIL mdu0_busy t+%0d got=%b exp=1", k, mdu_busy); end
            checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mdu0_stall t+%0d got=%b exp=0", k, stall); end
            step();
        end
    endtask

    task automatic test_flush();
        clear_inputs();
        ex_valid = 1'b1; ex_src_idx[0 +: RW] = 8; ex_src_use = 2'b01;
        mdu_start = 1'b1; mdu_wreg = 8;
        step();
        mdu_start = 1'b0;
        step();
        checks++; if (mdu_busy !== 1'b1) begin errors++; $display("FAIL flush_pre_busy got=%b exp=1", mdu_busy); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int k = 3; k <= 6; k++) begin
            #1;
            checks++; if (mdu_busy !== 1'b0) begin errors++; $display("FAIL flush_busy t+%0d got=%b exp=0", k, mdu_busy); end
            checks++; if (mdu_done !== 1'b0) begin errors++; $display("FAIL flush_done t+%0d got=%b exp=0", k, mdu_done); end
            checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall t+%0d got=%b exp=0", k, stall); end
            step();
        end
        flush = 1'b1; mdu_start = 1'b1;
        step();
        flush = 1'b0; mdu_start = 1'b0;
        #1;
        checks++; if (mdu_busy !== 1'b0) begin errors++; $display("FAIL flush_vs_start_busy got=%b exp=0", mdu_busy); end
        step();
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        ex_valid = 1'b1; ex_src_idx[0 +: RW] = 8; ex_src_use = 2'b01;
        mdu_start = 1'b1; mdu_wreg = 8;
        step();
        mdu_start = 1'b0;
        step();
        reset = 1'b1;
        step();
        #1;
        checks++; if (mdu_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", mdu_busy); end
        checks++; if (mdu_done !== 1'b0) begin errors++; $display("FAIL rstmid_done got=%b exp=0", mdu_done); end
        checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL rstmid_stall_cnt got=%0d exp=0", stall_cnt); end
        checks++; if (mdu_err !== 1'b0) begin errors++; $display("FAIL rstmid_err got=%b exp=0", mdu_err); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rstmid_stall got=%b exp=0", stall); end
        clear_inputs();
        reset = 1'b0;
    endtask

    task automatic test_counters();
        clear_inputs();
        ex_valid = 1'b1; ex_src_idx[0 +: RW] = 5; ex_src_use = 2'b01;
        stg_wreg[0 +: RW] = 5; stg_data_ok = 3'b000;
        for (int k = 1; k <= 70; k++) begin
            step();
            checks++; if (hang !== (k >= MAXS)) begin errors++; $display("FAIL hang after %0d stalls got=%b exp=%b", k, hang, k >= MAXS); end
        end
        checks++; if (stall_cnt !== 32'd70) begin errors++; $display("FAIL cnt_70 got=%0d exp=70", stall_cnt); end
        ex_src_use = 2'b00;
        for (int k = 0; k < 5; k++) step();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL release_stall got=%b exp=0", stall); end
        checks++; if (hang !== 1'b1) begin errors++; $display("FAIL hang_sticky got=%b exp=1", hang); end
        checks++; if (stall_cnt !== 32'd70) begin errors++; $display("FAIL cnt_hold got=%0d exp=70", stall_cnt); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        checks++; if (hang !== 1'b0) begin errors++; $display("FAIL hang_reset got=%b exp=0", hang); end
    endtask

    initial begin
        m_stall_cnt = 0; m_run = 0; m_hang = 0; m_rem = 0; m_reg = 0; m_err = 0;
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_priority();
        test_load_use();
        test_reg_zero();
        test_random_fwd();
        test_mdu();
        test_flush();
        test_reset_mid();
        test_counters();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
